// File: rtl/coef_fifo_loader.sv
// coef_fifo_loader: streams filter coefficients from a FIFO into the
// inactive bank of a double-buffered coefficient RAM, then swaps banks.
module coef_fifo_loader #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 1023
) (
  input  logic              wrclock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_taps,
  input  logic              abort,
  input  logic              frame_sync,
  input  logic              fifo_empty,
  input  logic [15:0]       fifo_q,
  output logic              fifo_rdreq,
  output logic              coef_we,
  output logic [ADDR_W-1:0] coef_addr,
  output logic [15:0]       coef_wdata,
  output logic              coef_bank,
  output logic              active_bank,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TW = $clog2(TIMEOUT + 1) + 1;

  localparam logic [ADDR_W:0] MAX_TAPS =
    {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE =
    {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [TW-1:0] TMO_ONE =
    {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    SWAP_WAIT = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_W:0] taps;
  logic [ADDR_W:0] issued;
  logic [ADDR_W:0] wr_cnt;
  logic [TW-1:0]   tmo;
  logic            rd_valid;

  logic start_ok;
  logic start_bad;
  logic last_wr;
  logic tmo_hit;
  logic swap;

  // Event decode shared by the FSM and the datapath.
  always_comb begin
    start_ok  = 1'b0;
    start_bad = 1'b0;
    if (state == IDLE && start) begin
      if (num_taps != '0 && num_taps <= MAX_TAPS)
        start_ok = 1'b1;
      else
        start_bad = 1'b1;
    end
    last_wr = coef_we && (wr_cnt == taps - CNT_ONE);
    tmo_hit = (state == LOAD) && !fifo_rdreq
              && (tmo == TMO_LAST);
    swap    = (state == SWAP_WAIT) && frame_sync
              && !abort;
  end

  // State register; reset drops any load in progress.
  always_ff @(posedge wrclock or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next state: abort beats completion, completion beats timeout.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start_ok)
          state_nx = LOAD;
      end
      LOAD: begin
        if (abort)
          state_nx = IDLE;
        else if (last_wr)
          state_nx = SWAP_WAIT;
        else if (tmo_hit)
          state_nx = IDLE;
      end
      SWAP_WAIT: begin
        if (abort || frame_sync)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs; a read in flight when abort arrives is dropped.
  always_comb begin
    busy       = (state != IDLE);
    fifo_rdreq = (state == LOAD) && !fifo_empty
                 && (issued < taps) && !abort;
    coef_we    = (state == LOAD) && rd_valid && !abort;
    coef_addr  = wr_cnt[ADDR_W-1:0];
    coef_wdata = coef_we ? fifo_q : '0;
    coef_bank  = ~active_bank;
  end

  // Counters, read pipeline, bank select and status pulses.
  always_ff @(posedge wrclock or negedge reset_n) begin
    if (!reset_n) begin
      taps        <= '0;
      issued      <= '0;
      wr_cnt      <= '0;
      tmo         <= '0;
      rd_valid    <= 1'b0;
      active_bank <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      rd_valid <= fifo_rdreq;
      if (start_ok) begin
        taps   <= num_taps;
        issued <= '0;
        wr_cnt <= '0;
        tmo    <= '0;
      end else begin
        if (fifo_rdreq)
          issued <= issued + CNT_ONE;
        if (coef_we)
          wr_cnt <= wr_cnt + CNT_ONE;
        if (state == LOAD)
          tmo <= fifo_rdreq ? '0 : tmo + TMO_ONE;
      end
      active_bank <= active_bank ^ swap;
      done        <= swap;
      err         <= start_bad
                     || (tmo_hit && !abort && !last_wr);
    end
  end

endmodule

// File: tb/tb_coef_fifo_loader.sv
// tb_coef_fifo_loader: randomized bench with a queue-style FIFO model
// and a write log compared against the expected coefficient stream.
module tb_coef_fifo_loader;

  localparam int AW = 9;

  logic wrclock = 1'b0;
  always #5 wrclock = ~wrclock;

  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          start_t = 1'b0;
  logic [AW:0]   num_taps = '0;
  logic          abort = 1'b0;
  logic          frame_sync = 1'b0;
  logic          fifo_empty;
  logic [15:0]   fifo_q = '0;

  logic          fifo_rdreq, coef_we, coef_bank;
  logic          active_bank, busy, done, err;
  logic [AW-1:0] coef_addr;
  logic [15:0]   coef_wdata;

  logic          t_rdreq, t_we, t_bank;
  logic          t_active, t_busy, t_done, t_err;
  logic [AW-1:0] t_addr;
  logic [15:0]   t_wdata;

  coef_fifo_loader #(.ADDR_W(AW), .TIMEOUT(1023)) dut (
    .wrclock(wrclock), .reset_n(reset_n),
    .start(start), .num_taps(num_taps),
    .abort(abort), .frame_sync(frame_sync),
    .fifo_empty(fifo_empty), .fifo_q(fifo_q),
    .fifo_rdreq(fifo_rdreq), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_bank(coef_bank), .active_bank(active_bank),
    .busy(busy), .done(done), .err(err)
  );

  coef_fifo_loader #(.ADDR_W(AW), .TIMEOUT(16)) dut_t (
    .wrclock(wrclock), .reset_n(reset_n),
    .start(start_t), .num_taps(num_taps),
    .abort(abort), .frame_sync(frame_sync),
    .fifo_empty(fifo_empty), .fifo_q(fifo_q),
    .fifo_rdreq(t_rdreq), .coef_we(t_we),
    .coef_addr(t_addr), .coef_wdata(t_wdata),
    .coef_bank(t_bank), .active_bank(t_active),
    .busy(t_busy), .done(t_done), .err(t_err)
  );

  // FIFO model: array with read/write pointers, non-showahead read.
  logic [15:0] mem [0:1023];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic sel = 1'b0;
  logic flush = 1'b0;
  logic rd_mux;

  assign rd_mux     = sel ? t_rdreq : fifo_rdreq;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge wrclock) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (rd_mux && rd_ptr != wr_ptr) begin
      fifo_q <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Event log of the main instance, sampled mid-cycle.
  int          cyc = 0;
  int          viol = 0;
  int          ndone = 0;
  int          nerr = 0;
  int          rd_cyc_q[$];
  int          wc_q[$];
  logic [AW-1:0] wa_q[$];
  logic [15:0] wd_q[$];
  logic        wb_q[$];

  always @(negedge wrclock) begin
    if (reset_n) begin
      cyc <= cyc + 1;
      if (fifo_rdreq) rd_cyc_q.push_back(cyc);
      if (fifo_rdreq && fifo_empty) viol <= viol + 1;
      if (coef_we) begin
        wa_q.push_back(coef_addr);
        wd_q.push_back(coef_wdata);
        wb_q.push_back(coef_bank);
        wc_q.push_back(cyc);
      end
      if (done) ndone <= ndone + 1;
      if (err) nerr <= nerr + 1;
    end
  end

  int   nvec = 0;
  int   nmis = 0;
  logic exp_active = 1'b0;

  task automatic tick();
    @(posedge wrclock);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic pulse_start(input int n);
    start = 1'b1;
    num_taps = (AW+1)'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic flush_fifo();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_writes(input int target,
                             input int limit,
                             output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (wa_q.size() >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    push(16'h5a5a);
    repeat (3) @(posedge wrclock);
    #2;
    nvec++;
    if ({busy, done, err, coef_we, fifo_rdreq, active_bank}
        !== 6'b0) begin
      nmis++;
      $display("FAIL reset_flags: got %b want 000000",
               {busy, done, err, coef_we, fifo_rdreq,
                active_bank});
    end
    nvec++;
    if (coef_addr !== '0 || coef_wdata !== '0) begin
      nmis++;
      $display("FAIL reset_port: addr %0h data %0h want 0 0",
               coef_addr, coef_wdata);
    end
    nvec++;
    if (coef_bank !== 1'b1) begin
      nmis++;
      $display("FAIL reset_bank: got %b want 1", coef_bank);
    end
    flush = 1'b1;
    @(posedge wrclock);
    #1;
    flush = 1'b0;
    reset_n = 1'b1;
    exp_active = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int rb, wb, db;
    bit ok;
    rb = rd_cyc_q.size();
    wb = wa_q.size();
    db = ndone;
    for (int i = 0; i < 8; i++) push(16'h0100 + 16'(i));
    pulse_start(8);
    wait_writes(wb + 8, 40, ok);
    nvec++;
    if (!ok) begin
      nmis++;
      $display("FAIL basic_timeout: got %0d writes want 8",
               wa_q.size() - wb);
    end
    nvec++;
    if (rd_cyc_q.size() - rb != 8) begin
      nmis++;
      $display("FAIL basic_rdcount: got %0d want 8",
               rd_cyc_q.size() - rb);
    end
    for (int i = 0; i < 8; i++) begin
      nvec++;
      if (rd_cyc_q[rb+i] != rd_cyc_q[rb] + i
          || wa_q[wb+i] !== AW'(i)
          || wd_q[wb+i] !== 16'h0100 + 16'(i)
          || wb_q[wb+i] !== 1'b1
          || wc_q[wb+i] != rd_cyc_q[rb+i] + 1) begin
        nmis++;
        $display("FAIL basic_wr[%0d]: a=%0h d=%0h b=%b want %0h %0h 1",
                 i, wa_q[wb+i], wd_q[wb+i], wb_q[wb+i],
                 i, 16'h0100 + 16'(i));
      end
    end
    repeat (3) tick();
    nvec++;
    if (busy !== 1'b1 || ndone != db) begin
      nmis++;
      $display("FAIL basic_wait: busy %b dones %0d want 1 0",
               busy, ndone - db);
    end
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    exp_active = ~exp_active;
    nvec++;
    if (done !== 1'b1 || active_bank !== exp_active) begin
      nmis++;
      $display("FAIL basic_swap: done %b bank %b want 1 %b",
               done, active_bank, exp_active);
    end
    tick();
    nvec++;
    if (done !== 1'b0 || busy !== 1'b0 || ndone - db != 1) begin
      nmis++;
      $display("FAIL basic_after: done %b busy %b n %0d want 0 0 1",
               done, busy, ndone - db);
    end
  endtask

  task automatic test_gaps();
    logic [15:0] d [0:4];
    int rb, wb, db, v0;
    bit ok;
    rb = rd_cyc_q.size();
    wb = wa_q.size();
    db = ndone;
    v0 = viol;
    for (int i = 0; i < 5; i++) d[i] = 16'($urandom);
    for (int i = 0; i < 3; i++) push(d[i]);
    pulse_start(5);
    for (int i = 0; i < 20; i++) begin
      frame_sync = (i == 10);
      tick();
    end
    frame_sync = 1'b0;
    nvec++;
    if (busy !== 1'b1 || ndone != db
        || active_bank !== exp_active
        || wa_q.size() - wb != 3) begin
      nmis++;
      $display("FAIL gaps_mid: busy %b dones %0d wr %0d want 1 0 3",
               busy, ndone - db, wa_q.size() - wb);
    end
    push(d[3]);
    push(d[4]);
    wait_writes(wb + 5, 20, ok);
    nvec++;
    if (!ok || rd_cyc_q.size() - rb != 5 || viol != v0) begin
      nmis++;
      $display("FAIL gaps_count: wr %0d rd %0d viol %0d want 5 5 0",
               wa_q.size() - wb, rd_cyc_q.size() - rb, viol - v0);
    end
    for (int i = 0; i < 5; i++) begin
      nvec++;
      if (wa_q[wb+i] !== AW'(i) || wd_q[wb+i] !== d[i]
          || wb_q[wb+i] !== ~exp_active) begin
        nmis++;
        $display("FAIL gaps_wr[%0d]: a=%0h d=%0h want %0h %0h",
                 i, wa_q[wb+i], wd_q[wb+i], i, d[i]);
      end
    end
    tick();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    exp_active = ~exp_active;
    nvec++;
    if (done !== 1'b1 || active_bank !== exp_active) begin
      nmis++;
      $display("FAIL gaps_swap: done %b bank %b want 1 %b",
               done, active_bank, exp_active);
    end
    tick();
  endtask

  task automatic test_bad_start();
    int rb, e0;
    rb = rd_cyc_q.size();
    e0 = nerr;
    push(16'h1234);
    pulse_start(0);
    nvec++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      nmis++;
      $display("FAIL bad_zero: err %b busy %b want 1 0", err, busy);
    end
    tick();
    pulse_start(513);
    nvec++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      nmis++;
      $display("FAIL bad_big: err %b busy %b want 1 0", err, busy);
    end
    tick();
    nvec++;
    if (err !== 1'b0 || nerr - e0 != 2
        || rd_cyc_q.size() != rb) begin
      nmis++;
      $display("FAIL bad_after: err %b n %0d rd %0d want 0 2 0",
               err, nerr - e0, rd_cyc_q.size() - rb);
    end
    flush_fifo();
  endtask

  task automatic test_timeout();
    logic [15:0] d [0:1];
    int idle, nw;
    bit  errbad;
    sel = 1'b1;
    idle = 0;
    nw = 0;
    errbad = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d[i] = 16'($urandom);
      push(d[i]);
    end
    start_t = 1'b1;
    num_taps = (AW+1)'(4);
    tick();
    start_t = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (t_err) break;
      if (t_busy) begin
        if (t_rdreq) idle = 0;
        else idle++;
      end
      if (t_we) begin
        if (t_addr !== AW'(nw) || t_wdata !== d[nw & 1])
          errbad = 1'b1;
        nw++;
      end
      if (t_done) errbad = 1'b1;
      tick();
    end
    nvec++;
    if (t_err !== 1'b1 || idle != 16) begin
      nmis++;
      $display("FAIL tmo_err: err %b idle %0d want 1 16",
               t_err, idle);
    end
    nvec++;
    if (t_busy !== 1'b0 || t_active !== 1'b0
        || t_bank !== 1'b1 || nw != 2 || errbad) begin
      nmis++;
      $display("FAIL tmo_state: busy %b bank %b wr %0d want 0 0 2",
               t_busy, t_active, nw);
    end
    tick();
    nvec++;
    if (t_err !== 1'b0) begin
      nmis++;
      $display("FAIL tmo_pulse: err %b want 0", t_err);
    end
    sel = 1'b0;
    flush_fifo();
  endtask

  task automatic test_abort();
    logic [15:0] d [0:5];
    int rb, wb, db;
    bit ok;
    rb = rd_cyc_q.size();
    wb = wa_q.size();
    db = ndone;
    for (int i = 0; i < 6; i++) begin
      d[i] = 16'($urandom);
      push(d[i]);
    end
    pulse_start(6);
    for (int i = 0; i < 20; i++) begin
      if (rd_cyc_q.size() >= rb + 3) break;
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    nvec++;
    if (busy !== 1'b0) begin
      nmis++;
      $display("FAIL abort_idle: busy %b want 0", busy);
    end
    repeat (4) tick();
    nvec++;
    if (rd_cyc_q.size() - rb != 3 || wa_q.size() - wb > 3
        || ndone != db) begin
      nmis++;
      $display("FAIL abort_count: rd %0d wr %0d done %0d want 3 <=3 0",
               rd_cyc_q.size() - rb, wa_q.size() - wb, ndone - db);
    end
    for (int i = wb; i < wa_q.size(); i++) begin
      nvec++;
      if (wa_q[i] !== AW'(i - wb) || wd_q[i] !== d[i-wb]) begin
        nmis++;
        $display("FAIL abort_wr[%0d]: a=%0h d=%0h want %0h %0h",
                 i - wb, wa_q[i], wd_q[i], i - wb, d[i-wb]);
      end
    end
    flush_fifo();
    wb = wa_q.size();
    push(16'hbeef);
    push(16'hcafe);
    pulse_start(2);
    wait_writes(wb + 2, 20, ok);
    tick();
    abort = 1'b1;
    frame_sync = 1'b1;
    tick();
    abort = 1'b0;
    frame_sync = 1'b0;
    nvec++;
    if (!ok || active_bank !== exp_active || done !== 1'b0
        || busy !== 1'b0) begin
      nmis++;
      $display("FAIL abort_swap: bank %b done %b busy %b want %b 0 0",
               active_bank, done, busy, exp_active);
    end
    tick();
    nvec++;
    if (ndone != db) begin
      nmis++;
      $display("FAIL abort_done: got %0d want 0", ndone - db);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d [0:1];
    int wb;
    bit ok;
    wb = wa_q.size();
    for (int i = 0; i < 10; i++) push(16'($urandom));
    pulse_start(10);
    wait_writes(wb + 4, 20, ok);
    reset_n = 1'b0;
    #2;
    exp_active = 1'b0;
    nvec++;
    if ({busy, done, err, coef_we, fifo_rdreq, active_bank}
        !== 6'b0 || coef_addr !== '0 || coef_wdata !== '0
        || coef_bank !== 1'b1) begin
      nmis++;
      $display("FAIL rstmid_out: flags %b addr %0h want 0 0",
               {busy, done, err, coef_we, fifo_rdreq,
                active_bank}, coef_addr);
    end
    tick();
    reset_n = 1'b1;
    tick();
    nvec++;
    if (busy !== 1'b0 || coef_we !== 1'b0) begin
      nmis++;
      $display("FAIL rstmid_rel: busy %b we %b want 0 0",
               busy, coef_we);
    end
    flush_fifo();
    wb = wa_q.size();
    for (int i = 0; i < 2; i++) begin
      d[i] = 16'($urandom);
      push(d[i]);
    end
    pulse_start(2);
    wait_writes(wb + 2, 20, ok);
    for (int i = 0; i < 2; i++) begin
      nvec++;
      if (!ok || wa_q[wb+i] !== AW'(i) || wd_q[wb+i] !== d[i]
          || wb_q[wb+i] !== 1'b1) begin
        nmis++;
        $display("FAIL rstmid_wr[%0d]: a=%0h d=%0h want %0h %0h",
                 i, wa_q[wb+i], wd_q[wb+i], i, d[i]);
      end
    end
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    exp_active = ~exp_active;
    nvec++;
    if (done !== 1'b1 || active_bank !== exp_active) begin
      nmis++;
      $display("FAIL rstmid_swap: done %b bank %b want 1 %b",
               done, active_bank, exp_active);
    end
    tick();
  endtask

  task automatic test_random();
    logic [15:0] d [0:15];
    int n, pushed, chunk, rb, wb, db, v0;
    bit ok;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) d[k] = 16'($urandom);
      rb = rd_cyc_q.size();
      wb = wa_q.size();
      db = ndone;
      v0 = viol;
      pushed = 0;
      pulse_start(n);
      while (pushed < n) begin
        chunk = $urandom_range(1, 4);
        for (int j = 0; j < chunk && pushed < n; j++) begin
          push(d[pushed]);
          pushed++;
        end
        repeat ($urandom_range(0, 4)) tick();
      end
      wait_writes(wb + n, 60, ok);
      nvec++;
      if (!ok || rd_cyc_q.size() - rb != n || viol != v0) begin
        nmis++;
        $display("FAIL rand%0d_count: wr %0d rd %0d viol %0d want %0d",
                 it, wa_q.size() - wb, rd_cyc_q.size() - rb,
                 viol - v0, n);
      end
      for (int k = 0; k < n; k++) begin
        nvec++;
        if (wa_q[wb+k] !== AW'(k) || wd_q[wb+k] !== d[k]
            || wb_q[wb+k] !== ~exp_active) begin
          nmis++;
          $display("FAIL rand%0d_wr[%0d]: a=%0h d=%0h want %0h %0h",
                   it, k, wa_q[wb+k], wd_q[wb+k], k, d[k]);
        end
      end
      repeat ($urandom_range(0, 3)) tick();
      nvec++;
      if (busy !== 1'b1) begin
        nmis++;
        $display("FAIL rand%0d_busy: got %b want 1", it, busy);
      end
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      exp_active = ~exp_active;
      nvec++;
      if (done !== 1'b1 || active_bank !== exp_active) begin
        nmis++;
        $display("FAIL rand%0d_swap: done %b bank %b want 1 %b",
                 it, done, active_bank, exp_active);
      end
      tick();
      nvec++;
      if (busy !== 1'b0 || ndone - db != 1) begin
        nmis++;
        $display("FAIL rand%0d_end: busy %b dones %0d want 0 1",
                 it, busy, ndone - db);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_bad_start();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
